and_unit_rr_arbiter: RTL and testbench
======================================

// Module: and_unit_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one registered AND unit among NUM_REQ requesters.
//   Per job: accepts one operand pair, drives the shared unit, waits out its latency, then returns
//   the result with the requester ID on a single valid/ready response bus.
//   Sits between the requester clients and the single shared registered AND datapath instance.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..16)
//   DATA_W    8   operand/result width in bits
//   UNIT_LAT  1   shared unit latency: cycles from unit_a/unit_b stable to valid unit_y (>=1)
// PORTS
//   clk         in   1                clock; all logic on posedge
//   rst         in   1                synchronous, active-high reset
//   req_valid   in   NUM_REQ          per-requester request valid
//   req_ready   out  NUM_REQ          per-requester accept (at most one bit high)
//   req_a       in   NUM_REQ*DATA_W   operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b       in   NUM_REQ*DATA_W   operand B, same packing
//   unit_a      out  DATA_W           operand A to shared unit
//   unit_b      out  DATA_W           operand B to shared unit
//   unit_y      in   DATA_W           result from shared unit
//   resp_valid  out  1                response valid
//   resp_ready  in   1                response consumer ready
//   resp_y      out  DATA_W           result (unit_y sampled)
//   resp_id     out  $clog2(NUM_REQ)  index of requester that owns resp_y
// BEHAVIOUR
//   - Reset: state=IDLE; rr_ptr=0; req_ready=0; unit_a=unit_b=0; resp_valid=0; resp_y=0; resp_id=0.
//   - Reset mid-operation: in-flight job dropped, no response issued, rr_ptr back to 0.
//   - FSM: IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE:
//       - Winner = first i with req_valid[i]=1, searching upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
//       - req_ready[winner]=1 combinationally; all other req_ready bits 0; req_ready all 0 outside IDLE.
//       - Handshake = req_valid[i] & req_ready[i].
//       - On handshake: latch req_a/req_b of winner into unit_a/unit_b and winner into resp_id;
//         rr_ptr <= (winner+1) mod NUM_REQ; next state EXEC.
//       - No request: stay IDLE, rr_ptr unchanged.
//   - EXEC:
//       - Lasts exactly UNIT_LAT+1 cycles; unit_a/unit_b held constant throughout.
//       - On the final EXEC cycle, unit_y is sampled into resp_y; next state RESP.
//   - RESP:
//       - resp_valid=1; resp_y and resp_id held stable until resp_valid & resp_ready.
//       - On handshake: resp_valid=0 and next state IDLE.
//   - Timing (handshake in cycle A): resp_valid first high in cycle A+UNIT_LAT+2.
//   - Throughput: at most one job per UNIT_LAT+3 cycles, with resp_ready tied high.
//   - unit_a/unit_b retain the last operands after a job; they change only on the next accept.
//   - Requesters hold req_valid and operands until accepted. Requests raised while not in IDLE
//     wait; arbitration is evaluated only in IDLE.
//   - resp_ready high before resp_valid has no effect.
//   - resp_ready high on the first RESP cycle gives a single-cycle resp_valid pulse.
//   - Fairness: a requester continuously asserting req_valid is accepted within NUM_REQ jobs.
// CONFIGURATION
//   GATE_ARB_STATS_EN defined:
//     - Adds output op_count [15:0], reset 0.
//     - Increments by 1 on each resp_valid&resp_ready handshake; saturates at 16'hFFFF.
//   GATE_ARB_STATS_EN undefined:
//     - op_count port and counter absent; all other behaviour identical.
// TESTING
//   - Reset: rst=1 for 2 cycles -> all outputs 0, req_ready=0.
//   - Single job, resp_ready=1:
//       - Stimulus: req_valid=4'b0001, a=8'hF0, b=8'h3C, accepted in cycle A.
//       - Expect: unit_a=F0 and unit_b=3C from A+1; resp_valid=1 at A+3 with resp_y=8'h30, resp_id=0.
//   - Round-robin order:
//       - Stimulus: req_valid=4'b1111 held, resp_ready=1.
//       - Expect: grants in order 0,1,2,3,0; every resp_y equals the AND of that requester's operands.
//   - Wrap-around:
//       - Stimulus: rr_ptr=3 (after a grant to 2); req_valid=4'b1001.
//       - Expect: grant 3, then grant 0.
//   - Backpressure:
//       - Stimulus: resp_ready=0 for 5 cycles during RESP.
//       - Expect: resp_valid, resp_y and resp_id stable; req_ready=0 throughout; release -> IDLE next cycle.
//   - Mid-operation reset:
//       - Stimulus: rst=1 in second EXEC cycle.
//       - Expect: next cycle state IDLE, resp_valid=0, no response for the dropped job.
//       - Expect (GATE_ARB_STATS_EN): op_count=0.

Source files
------------

// File: rtl/and_unit_rr_arbiter_if.sv
// Bundle of request, shared-unit and response signals for the round-robin
// AND-unit arbiter. The arbiter connects through the slave modport; the
// requester/unit/consumer side connects through the master modport.
interface and_unit_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [DATA_W-1:0]         unit_a;
  logic [DATA_W-1:0]         unit_b;
  logic [DATA_W-1:0]         unit_y;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_W-1:0]         resp_y;
  logic [ID_W-1:0]           resp_id;

  modport master (
    output req_valid, req_a, req_b, unit_y, resp_ready,
    input  req_ready, unit_a, unit_b, resp_valid, resp_y, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, unit_y, resp_ready,
    output req_ready, unit_a, unit_b, resp_valid, resp_y, resp_id
  );
endinterface

// File: rtl/and_unit_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered AND unit among
// NUM_REQ requesters. One job at a time: IDLE (arbitrate/accept) ->
// EXEC (UNIT_LAT+1 cycles) -> RESP (hold result until consumed).
// Optional feature macro: GATE_ARB_STATS_EN adds a saturating 16-bit
// op_count output counting completed response handshakes.
module and_unit_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int UNIT_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  and_unit_rr_arbiter_if.slave bus
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [15:0]          op_count
`endif
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(UNIT_LAT + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   ptr_next;
  logic              found;
  logic              accept;
  logic [CNT_W-1:0]  exec_cnt;

  // Pick the first valid requester at or above rr_ptr, wrapping to 0.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign accept   = (state == IDLE) && found && !rst;
  assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Grant only the winner, only while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
  end

  // Job sequencer: accept, wait out the unit latency, then hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      exec_cnt       <= '0;
      bus.unit_a     <= '0;
      bus.unit_b     <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_y     <= '0;
      bus.resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.unit_a  <= bus.req_a[int'(winner)*DATA_W +: DATA_W];
            bus.unit_b  <= bus.req_b[int'(winner)*DATA_W +: DATA_W];
            bus.resp_id <= winner;
            rr_ptr      <= ptr_next;
            exec_cnt    <= '0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (exec_cnt == CNT_W'(UNIT_LAT)) begin
            bus.resp_y     <= bus.unit_y;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            exec_cnt <= exec_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_ARB_STATS_EN
  // Count consumed responses, sticking at the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (bus.resp_valid && bus.resp_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_and_unit_rr_arbiter.sv
// Directed bench for and_unit_rr_arbiter: table of single jobs covering
// round-robin order and wrap-around, plus hand-written backpressure and
// mid-operation reset sequences. Models the shared registered AND unit.
module tb_and_unit_rr_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int UNIT_LAT = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  and_unit_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef GATE_ARB_STATS_EN
  logic [15:0] op_count;
`endif

  and_unit_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .UNIT_LAT(UNIT_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef GATE_ARB_STATS_EN
    ,
    .op_count(op_count)
`endif
  );

  // Shared registered AND unit, one cycle of latency.
  always @(posedge clk) bus.unit_y <= bus.unit_a & bus.unit_b;

  typedef struct {
    logic [3:0] mask;
    int         exp_id;
    logic [7:0] exp_y;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] op_a [4];
  logic [7:0] op_b [4];
  int         n_vectors     = 0;
  int         n_miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] mask, input logic rready);
    bus.req_valid  = mask;
    bus.resp_ready = rready;
    #1;
  endtask

  task automatic run_job(input logic [3:0] mask, input int exp_id, input logic [7:0] exp_y);
    logic [3:0] onehot;
    onehot = 4'b0001 << exp_id;
    apply_stimulus(mask, 1'b1);
    check_output("req_ready_grant", 32'(bus.req_ready), 32'(onehot));
    step();
    check_output("unit_a", 32'(bus.unit_a), 32'(op_a[exp_id]));
    check_output("unit_b", 32'(bus.unit_b), 32'(op_b[exp_id]));
    check_output("req_ready_exec", 32'(bus.req_ready), 32'd0);
    step();
    check_output("resp_valid_early", 32'(bus.resp_valid), 32'd0);
    step();
    check_output("resp_valid", 32'(bus.resp_valid), 32'd1);
    check_output("resp_y", 32'(bus.resp_y), 32'(exp_y));
    check_output("resp_id", 32'(bus.resp_id), 32'(exp_id));
    check_output("req_ready_resp", 32'(bus.req_ready), 32'd0);
    step();
    check_output("resp_valid_done", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    op_a = '{8'hF0, 8'h5A, 8'h33, 8'hFF};
    op_b = '{8'h3C, 8'h0F, 8'h66, 8'h81};
    bus.req_a      = {op_a[3], op_a[2], op_a[1], op_a[0]};
    bus.req_b      = {op_b[3], op_b[2], op_b[1], op_b[0]};
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    rst            = 1'b1;

    vecs[0]  = '{4'b0001, 0, 8'h30};
    vecs[1]  = '{4'b1111, 1, 8'h0A};
    vecs[2]  = '{4'b1111, 2, 8'h22};
    vecs[3]  = '{4'b1111, 3, 8'h81};
    vecs[4]  = '{4'b1111, 0, 8'h30};
    vecs[5]  = '{4'b0100, 2, 8'h22};
    vecs[6]  = '{4'b1001, 3, 8'h81};
    vecs[7]  = '{4'b1001, 0, 8'h30};
    vecs[8]  = '{4'b1000, 3, 8'h81};
    vecs[9]  = '{4'b0010, 1, 8'h0A};
    vecs[10] = '{4'b0001, 0, 8'h30};

    // Reset state
    step();
    step();
    check_output("rst_unit_a", 32'(bus.unit_a), 32'd0);
    check_output("rst_unit_b", 32'(bus.unit_b), 32'd0);
    check_output("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("rst_resp_y", 32'(bus.resp_y), 32'd0);
    check_output("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check_output("rst_req_ready", 32'(bus.req_ready), 32'd0);
    apply_stimulus(4'b1111, 1'b0);
    check_output("rst_req_ready_busy", 32'(bus.req_ready), 32'd0);
`ifdef GATE_ARB_STATS_EN
    check_output("rst_op_count", 32'(op_count), 32'd0);
`endif
    bus.req_valid = '0;
    rst           = 1'b0;

    // Table of single jobs: round-robin order and wrap-around
    for (int i = 0; i < 11; i++) begin
      run_job(vecs[i].mask, vecs[i].exp_id, vecs[i].exp_y);
    end
`ifdef GATE_ARB_STATS_EN
    check_output("op_count_jobs", 32'(op_count), 32'd11);
`endif

    // Backpressure: rr_ptr=1, requester 2 wins, consumer stalls 5+ cycles
    apply_stimulus(4'b0100, 1'b0);
    check_output("bp_grant", 32'(bus.req_ready), 32'b0100);
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check_output("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      check_output("bp_resp_y", 32'(bus.resp_y), 32'h22);
      check_output("bp_resp_id", 32'(bus.resp_id), 32'd2);
      check_output("bp_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    apply_stimulus(4'b0100, 1'b1);
    check_output("bp_resp_valid_held", 32'(bus.resp_valid), 32'd1);
    step();
    check_output("bp_release_valid", 32'(bus.resp_valid), 32'd0);
    check_output("bp_release_idle_grant", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = '0;
`ifdef GATE_ARB_STATS_EN
    check_output("op_count_bp", 32'(op_count), 32'd12);
`endif

    // Mid-operation reset: rr_ptr=3, requester 1 wins, reset in 2nd EXEC cycle
    apply_stimulus(4'b0010, 1'b1);
    check_output("mr_grant", 32'(bus.req_ready), 32'b0010);
    step();
    step();
    rst           = 1'b1;
    bus.req_valid = '0;
    step();
    check_output("mr_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("mr_req_ready", 32'(bus.req_ready), 32'd0);
    check_output("mr_unit_a", 32'(bus.unit_a), 32'd0);
`ifdef GATE_ARB_STATS_EN
    check_output("mr_op_count", 32'(op_count), 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("mr_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    // Pointer returned to 0: requester 0 wins despite all requesting
    run_job(4'b1111, 0, 8'h30);
    bus.req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
